// File: rtl/MEM_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// the latched request record and the address legality check.
package MEM_pkg;

  localparam int MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // A request is illegal when it is not word-aligned or indexes past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with four independently enabled byte lanes,
// a synchronous write port and a registered read port sharing one address.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // NOTE: the storage array has no reset on purpose; contents survive a reset
  // and a reset term would also prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed
// number of cycles, performs the access and holds the response until taken.
module dmem_responder
  import MEM_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES :
                          (WAIT_STATES < 0) ? 0 : WAIT_STATES;
  localparam logic [3:0] WAIT_LAST = (WS_EFF > 0) ? 4'(WS_EFF - 1) : 4'd0;

  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  mem_req_t    req_q,       req_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rd_valid_q,  rd_valid_d;

  mem_req_t    req_in;
  mem_req_t    op;
  logic        op_err;
  logic        enter_resp;
  logic        arr_we;
  logic        arr_re;
  logic [31:0] arr_rdata;

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the accept edge itself, so
  // the operation is taken straight from the ports rather than the latch.
  assign op     = (state_q == IDLE) ? req_in : req_q;
  assign op_err = addr_err(op.addr, DEPTH_WORDS);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_valid_d  = rd_valid_q;
    enter_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          cnt_d = '0;
          if (WS_EFF == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_valid_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = op_err;
      rd_valid_d  = !op.we && !op_err;
    end

    arr_we      = enter_resp && op.we && !op_err;
    arr_re      = enter_resp && !op.we && !op_err;
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (op.addr[ADDR_W+1:2]),
    .be    (op.be),
    .wdata (op.wdata),
    .rdata (arr_rdata)
  );

  // Writes and errors present zero; read data is only exposed for legal reads.
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_valid_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a two-wait-state instance for the main
// scenarios and a zero-wait instance with the response always accepted.
module tb_dmem_responder;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        m_req_valid, m_req_ready, m_req_we;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_be;
  logic        m_rsp_valid, m_rsp_ready, m_rsp_err;
  logic [31:0] m_rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #(PERIOD/2) clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_main (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .req_valid (m_req_valid),
    .req_ready (m_req_ready),
    .req_we    (m_req_we),
    .req_addr  (m_req_addr),
    .req_wdata (m_req_wdata),
    .req_be    (m_req_be),
    .rsp_valid (m_rsp_valid),
    .rsp_ready (m_rsp_ready),
    .rsp_rdata (m_rsp_rdata),
    .rsp_err   (m_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_zero (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_be    (z_req_be),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (1'b1),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  // One full transaction on the main instance, starting and ending at a negedge.
  // lat is the number of posedges from the accept edge to the first edge at
  // which the initiator sees rsp_valid high.
  task automatic m_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic rerr,
                       output int lat);
    int guard;
    m_req_valid = 1'b1;
    m_req_we    = we;
    m_req_addr  = addr;
    m_req_wdata = wdata;
    m_req_be    = be;
    guard = 0;
    while (!m_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b expected 1", addr, m_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    m_req_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = m_rsp_rdata;
    rerr  = m_rsp_err;
    m_rsp_ready = 1'b1;
    @(negedge clk);
    m_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_rsp_valid !== 1'b0 || m_rsp_err !== 1'b0 || m_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b err=%b rdata=%h expected 0/0/00000000",
               m_rsp_valid, m_rsp_err, m_rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_main req_ready=%b rsp_valid=%b expected 1/0",
               m_req_ready, m_rsp_valid);
    end
    checks++;
    if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_zero req_ready=%b rsp_valid=%b expected 1/0",
               z_req_ready, z_rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lat;
    m_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp err=%b rdata=%h expected 0/00000000", er, rd);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL wr_latency got %0d expected 3", lat);
    end
    m_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_full err=%b rdata=%h expected 0/deadbeef", er, rd);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rd_latency got %0d expected 3", lat);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd;
    logic        er;
    int          lat;
    m_txn(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, rd, er, lat);
    m_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL partial_merge err=%b rdata=%h expected 0/de22be44", er, rd);
    end
    m_txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_err got %b expected 0", er);
    end
    m_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL be_zero_noop rdata=%h expected de22be44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    m_txn(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    m_txn(1'b0, 32'h0000_0013, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_rd err=%b rdata=%h expected 1/00000000", er, rd);
    end
    m_txn(1'b0, 32'h0000_0002, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_rd2 err=%b rdata=%h expected 1/00000000", er, rd);
    end
    m_txn(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL range_wr err=%b rdata=%h expected 1/00000000", er, rd);
    end
    m_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL after_err_rd0 err=%b rdata=%h expected 0/cafef00d", er, rd);
    end
    m_txn(1'b1, 32'h0000_0FFC, 32'h0A0B_0C0D, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL last_word_wr err=%b expected 0", er);
    end
    m_txn(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0A0B_0C0D) begin
      errors++;
      $display("FAIL last_word_rd err=%b rdata=%h expected 0/0a0b0c0d", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;
    m_req_valid = 1'b1;
    m_req_we    = 1'b0;
    m_req_addr  = 32'h0000_0010;
    m_req_wdata = 32'h0;
    m_req_be    = 4'h0;
    guard = 0;
    while (!m_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    // A would-be corrupting write is held on the request port throughout.
    m_req_we    = 1'b1;
    m_req_addr  = 32'h0000_0000;
    m_req_wdata = 32'hBAD0_BAD0;
    m_req_be    = 4'hF;
    guard = 0;
    while (!m_rsp_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== 32'hDE22_BE44 || m_rsp_err !== 1'b0 ||
          m_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h err=%b req_ready=%b expected 1/de22be44/0/0",
                 i, m_rsp_valid, m_rsp_rdata, m_rsp_err, m_req_ready);
      end
      @(negedge clk);
    end
    m_rsp_ready = 1'b1;
    @(negedge clk);
    m_rsp_ready = 1'b0;
    checks++;
    if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release req_ready=%b rsp_valid=%b expected 1/0", m_req_ready, m_rsp_valid);
    end
    m_req_valid = 1'b0;
    @(negedge clk);
    m_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL bp_no_second_accept rdata=%h expected cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;
    m_txn(1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, rd, er, lat);
    m_req_valid = 1'b1;
    m_req_we    = 1'b1;
    m_req_addr  = 32'h0000_0020;
    m_req_wdata = 32'h2222_2222;
    m_req_be    = 4'hF;
    guard = 0;
    while (!m_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    m_req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_rsp_valid !== 1'b0 || m_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs valid=%b rdata=%h expected 0/00000000", m_rsp_valid, m_rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release valid=%b req_ready=%b expected 0/1", m_rsp_valid, m_req_ready);
    end
    m_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1111_1111) begin
      errors++;
      $display("FAIL mid_reset_old_value err=%b rdata=%h expected 0/11111111", er, rd);
    end
  endtask

  task automatic test_zero_wait();
    logic        we_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] adr_v [6] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h40, 32'h44};
    logic [31:0] dat_v [6] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0123_4567, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_v [6] = '{32'h0, 32'h0, 32'h0, 32'h0123_4567, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    time t_prev;
    time t_acc;
    int  guard;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      z_req_valid = 1'b1;
      z_req_we    = we_v[i];
      z_req_addr  = adr_v[i];
      z_req_wdata = dat_v[i];
      z_req_be    = 4'hF;
      guard = 0;
      while (!z_req_ready && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      checks++;
      if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== exp_v[i]) begin
        errors++;
        $display("FAIL zw_resp idx=%0d valid=%b err=%b rdata=%h expected 1/0/%h",
                 i, z_rsp_valid, z_rsp_err, z_rsp_rdata, exp_v[i]);
      end
      if (i > 0) begin
        checks++;
        if (t_acc - t_prev != 2 * PERIOD) begin
          errors++;
          $display("FAIL zw_spacing idx=%0d gap=%0t expected %0d", i, t_acc - t_prev, 2 * PERIOD);
        end
      end
      t_prev = t_acc;
    end
    z_req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    m_req_valid = 1'b0;
    m_req_we    = 1'b0;
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_be    = '0;
    m_rsp_ready = 1'b0;
    z_req_valid = 1'b0;
    z_req_we    = 1'b0;
    z_req_addr  = '0;
    z_req_wdata = '0;
    z_req_be    = '0;

    test_reset();
    test_write_read();
    test_partial_write();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_zero_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
